// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational ALU between two valid/ready requesters:
// requester 0 (pipeline execute stage) and requester 1 (debug/maintenance port).
// Only one operation is in flight at a time. The block latches the operands,
// drives the ALU for one cycle, registers the result, and holds it on the
// owner's response channel until the owner accepts it.
//
// Parameters:
//   FIXED_PRIO    : 0 = round-robin on ties, 1 = requester 0 always wins ties
// Ports:
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   reqN_valid    : requester N presents an operation
//   reqN_ready    : requester N's operation is accepted this cycle
//   reqN_val1/2   : 32-bit operands of requester N
//   reqN_aluop    : 5-bit ALU operation code of requester N
//   respN_valid   : result available for requester N
//   respN_ready   : requester N consumes the result
//   respN_result  : registered result (0 when respN_valid is low)
//   alu_val1/2    : operands to the ALU (0 outside the execute cycle)
//   alu_aluop     : operation code to the ALU (0 outside the execute cycle)
//   alu_is_alu_op : ALU enable, high only during the execute cycle
//   alu_result    : result returned by the ALU
module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_val1,
  input  logic [31:0] req0_val2,
  input  logic [4:0]  req0_aluop,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_val1,
  input  logic [31:0] req1_val2,
  input  logic [4:0]  req1_aluop,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [31:0] resp0_result,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp1_result,
  output logic [31:0] alu_val1,
  output logic [31:0] alu_val2,
  output logic [4:0]  alu_aluop,
  output logic        alu_is_alu_op,
  input  logic [31:0] alu_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        owner;
  logic        last;
  logic [31:0] op_val1;
  logic [31:0] op_val2;
  logic [4:0]  op_aluop;
  logic [31:0] result_q;
  logic        grant_sel;
  logic        accept;
  logic        resp_fire;

  // Grant selection among the currently valid requesters. A lone valid
  // requester always wins. On a tie, round-robin hands the grant to whoever
  // was not served last; fixed priority always picks requester 0. Because
  // 'last' resets to 1, requester 0 also wins the first round-robin tie.
  always_comb begin
    grant_sel = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_sel = FIXED_PRIO ? 1'b0 : ~last;
    end else if (req1_valid) begin
      grant_sel = 1'b1;
    end
  end

  // Next-state and output decode. Every output defaults to 0 so the ALU sees
  // zero operands and a cleared enable outside the execute cycle, and the
  // response channels show 0 unless they carry a valid result. Ready is only
  // offered in IDLE, so a response handshake and a new acceptance can never
  // land in the same cycle.
  always_comb begin
    next_state    = state;
    accept        = 1'b0;
    resp_fire     = 1'b0;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    resp0_valid   = 1'b0;
    resp1_valid   = 1'b0;
    resp0_result  = 32'd0;
    resp1_result  = 32'd0;
    alu_val1      = 32'd0;
    alu_val2      = 32'd0;
    alu_aluop     = 5'd0;
    alu_is_alu_op = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          accept     = 1'b1;
          req0_ready = ~grant_sel;
          req1_ready = grant_sel;
          next_state = EXEC;
        end
      end
      EXEC: begin
        alu_val1      = op_val1;
        alu_val2      = op_val2;
        alu_aluop     = op_aluop;
        alu_is_alu_op = 1'b1;
        next_state    = RESP;
      end
      RESP: begin
        if (owner) begin
          resp1_valid  = 1'b1;
          resp1_result = result_q;
          resp_fire    = resp1_ready;
        end else begin
          resp0_valid  = 1'b1;
          resp0_result = result_q;
          resp_fire    = resp0_ready;
        end
        if (resp_fire) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register. Reset drops any in-flight operation back to IDLE, so a
  // discarded operation never produces a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Datapath registers. Operands and the owner are captured from the granted
  // requester at acceptance, the ALU output is sampled at the edge closing
  // the execute cycle, and 'last' only advances once the owner has actually
  // consumed its result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner    <= 1'b0;
      last     <= 1'b1;
      op_val1  <= 32'd0;
      op_val2  <= 32'd0;
      op_aluop <= 5'd0;
      result_q <= 32'd0;
    end else begin
      if (accept) begin
        owner    <= grant_sel;
        op_val1  <= grant_sel ? req1_val1  : req0_val1;
        op_val2  <= grant_sel ? req1_val2  : req0_val2;
        op_aluop <= grant_sel ? req1_aluop : req0_aluop;
      end
      if (state == EXEC) begin
        result_q <= alu_result;
      end
      if (resp_fire) begin
        last <= owner;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Drives two alu_arbiter instances (index 0: round-robin, index 1: fixed
// priority) from shared requester stimulus. Each instance gets its own
// behavioural ALU and its own transaction-level reference model; a compare
// process checks every output of both instances on every falling edge.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic        req1_valid = 1'b0;
  logic [31:0] req0_val1 = '0;
  logic [31:0] req0_val2 = '0;
  logic [31:0] req1_val1 = '0;
  logic [31:0] req1_val2 = '0;
  logic [4:0]  req0_aluop = '0;
  logic [4:0]  req1_aluop = '0;
  logic        resp0_ready = 1'b0;
  logic        resp1_ready = 1'b0;

  logic [1:0]        d_req0_ready;
  logic [1:0]        d_req1_ready;
  logic [1:0]        d_resp0_valid;
  logic [1:0]        d_resp1_valid;
  logic [1:0][31:0]  d_resp0_result;
  logic [1:0][31:0]  d_resp1_result;
  logic [1:0][31:0]  d_alu_val1;
  logic [1:0][31:0]  d_alu_val2;
  logic [1:0][4:0]   d_alu_aluop;
  logic [1:0]        d_alu_is;
  logic [1:0][31:0]  d_alu_result;

  int checks = 0;
  int failures = 0;

  // Reference model state: an operation is outstanding (busy), how many
  // cycles since it was accepted (age), who owns it, and its operands.
  logic        m_busy  [2] = '{1'b0, 1'b0};
  int          m_age   [2] = '{0, 0};
  logic        m_owner [2] = '{1'b0, 1'b0};
  logic        m_last  [2] = '{1'b1, 1'b1};
  logic [31:0] m_a     [2] = '{32'd0, 32'd0};
  logic [31:0] m_b     [2] = '{32'd0, 32'd0};
  logic [4:0]  m_op    [2] = '{5'd0, 5'd0};

  logic        glog0 [$];
  logic        glog1 [$];
  logic [31:0] rlog0 [$];
  logic [31:0] rlog1 [$];

  // Behavioural ALU: ADD=0, SUB=1, MUL=2, XOR=3, anything else yields 0.
  function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a * b;
      5'd3:    return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  // Each instance's ALU outputs 0 whenever its enable is low.
  assign d_alu_result[0] = d_alu_is[0] ? alu_fn(d_alu_aluop[0], d_alu_val1[0], d_alu_val2[0]) : 32'd0;
  assign d_alu_result[1] = d_alu_is[1] ? alu_fn(d_alu_aluop[1], d_alu_val1[1], d_alu_val2[1]) : 32'd0;

  alu_arbiter #(.FIXED_PRIO(1'b0)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(d_req0_ready[0]),
    .req0_val1(req0_val1), .req0_val2(req0_val2), .req0_aluop(req0_aluop),
    .req1_valid(req1_valid), .req1_ready(d_req1_ready[0]),
    .req1_val1(req1_val1), .req1_val2(req1_val2), .req1_aluop(req1_aluop),
    .resp0_valid(d_resp0_valid[0]), .resp0_ready(resp0_ready), .resp0_result(d_resp0_result[0]),
    .resp1_valid(d_resp1_valid[0]), .resp1_ready(resp1_ready), .resp1_result(d_resp1_result[0]),
    .alu_val1(d_alu_val1[0]), .alu_val2(d_alu_val2[0]), .alu_aluop(d_alu_aluop[0]),
    .alu_is_alu_op(d_alu_is[0]), .alu_result(d_alu_result[0])
  );

  alu_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(d_req0_ready[1]),
    .req0_val1(req0_val1), .req0_val2(req0_val2), .req0_aluop(req0_aluop),
    .req1_valid(req1_valid), .req1_ready(d_req1_ready[1]),
    .req1_val1(req1_val1), .req1_val2(req1_val2), .req1_aluop(req1_aluop),
    .resp0_valid(d_resp0_valid[1]), .resp0_ready(resp0_ready), .resp0_result(d_resp0_result[1]),
    .resp1_valid(d_resp1_valid[1]), .resp1_ready(resp1_ready), .resp1_result(d_resp1_result[1]),
    .alu_val1(d_alu_val1[1]), .alu_val2(d_alu_val2[1]), .alu_aluop(d_alu_aluop[1]),
    .alu_is_alu_op(d_alu_is[1]), .alu_result(d_alu_result[1])
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [4:0] o0,
                               input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [4:0] o1,
                               input logic rr0, input logic rr1);
    req0_valid  = v0;
    req0_val1   = a0;
    req0_val2   = b0;
    req0_aluop  = o0;
    req1_valid  = v1;
    req1_val1   = a1;
    req1_val2   = b1;
    req1_aluop  = o1;
    resp0_ready = rr0;
    resp1_ready = rr1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    for (int i = 0; i < 2; i++) begin
      checkOutput({tag, "_reqReady"}, {62'd0, d_req1_ready[i], d_req0_ready[i]}, 64'd0);
      checkOutput({tag, "_respValid"}, {62'd0, d_resp1_valid[i], d_resp0_valid[i]}, 64'd0);
      checkOutput({tag, "_respResult"}, {d_resp1_result[i], d_resp0_result[i]}, 64'd0);
      checkOutput({tag, "_aluVals"}, {d_alu_val2[i], d_alu_val1[i]}, 64'd0);
      checkOutput({tag, "_aluCtl"}, {58'd0, d_alu_is[i], d_alu_aluop[i]}, 64'd0);
    end
  endtask

  // Compare process. On each falling edge the model works out, from the
  // current inputs and its transaction view, what every output must be,
  // checks the DUT, then advances to what the next rising edge will do.
  always @(negedge clk) begin
    logic [1:0]  e_rr;
    logic [1:0]  e_rv;
    logic [31:0] e_r0;
    logic [31:0] e_r1;
    logic [31:0] e_v1;
    logic [31:0] e_v2;
    logic [4:0]  e_op;
    logic        e_is;
    logic        g;
    for (int i = 0; i < 2; i++) begin
      e_rr = 2'b00;
      e_rv = 2'b00;
      e_r0 = 32'd0;
      e_r1 = 32'd0;
      e_v1 = 32'd0;
      e_v2 = 32'd0;
      e_op = 5'd0;
      e_is = 1'b0;
      if (rst) begin
        m_busy[i]  = 1'b0;
        m_age[i]   = 0;
        m_owner[i] = 1'b0;
        m_last[i]  = 1'b1;
      end else if (!m_busy[i]) begin
        if (req0_valid || req1_valid) begin
          if (req0_valid && req1_valid) g = (i == 1) ? 1'b0 : !m_last[i];
          else g = req1_valid;
          e_rr[g] = 1'b1;
          if (i == 0) glog0.push_back(g);
          else glog1.push_back(g);
          m_busy[i]  = 1'b1;
          m_age[i]   = 0;
          m_owner[i] = g;
          m_a[i]     = g ? req1_val1 : req0_val1;
          m_b[i]     = g ? req1_val2 : req0_val2;
          m_op[i]    = g ? req1_aluop : req0_aluop;
        end
      end else if (m_age[i] == 0) begin
        e_v1 = m_a[i];
        e_v2 = m_b[i];
        e_op = m_op[i];
        e_is = 1'b1;
        m_age[i] = 1;
      end else begin
        e_rv[m_owner[i]] = 1'b1;
        if (m_owner[i]) e_r1 = alu_fn(m_op[i], m_a[i], m_b[i]);
        else e_r0 = alu_fn(m_op[i], m_a[i], m_b[i]);
        if (m_owner[i] ? resp1_ready : resp0_ready) begin
          if (i == 0) rlog0.push_back(m_owner[i] ? d_resp1_result[i] : d_resp0_result[i]);
          else rlog1.push_back(m_owner[i] ? d_resp1_result[i] : d_resp0_result[i]);
          m_busy[i] = 1'b0;
          m_last[i] = m_owner[i];
        end
      end
      checkOutput($sformatf("m%0d_reqReady", i), {62'd0, d_req1_ready[i], d_req0_ready[i]}, {62'd0, e_rr});
      checkOutput($sformatf("m%0d_respValid", i), {62'd0, d_resp1_valid[i], d_resp0_valid[i]}, {62'd0, e_rv});
      checkOutput($sformatf("m%0d_resp0Result", i), {32'd0, d_resp0_result[i]}, {32'd0, e_r0});
      checkOutput($sformatf("m%0d_resp1Result", i), {32'd0, d_resp1_result[i]}, {32'd0, e_r1});
      checkOutput($sformatf("m%0d_aluVals", i), {d_alu_val2[i], d_alu_val1[i]}, {e_v2, e_v1});
      checkOutput($sformatf("m%0d_aluCtl", i), {58'd0, d_alu_is[i], d_alu_aluop[i]}, {58'd0, e_is, e_op});
    end
  end

  // Directed scenarios with hand-computed expectations, then random traffic.
  initial begin
    logic [4:0] rop;
    step(2);
    checkAllZero("reset");
    rst = 1'b0;
    step(1);

    // Single ADD 5+7 from requester 0.
    applyStimulus(1'b1, 32'd5, 32'd7, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);
    #1;
    checkOutput("single_req0Ready", {62'd0, d_req0_ready}, 64'd3);
    step(1);
    applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);
    #1;
    checkOutput("single_req0ReadyExec", {62'd0, d_req0_ready}, 64'd0);
    step(1);
    checkOutput("single_resp0Valid", {62'd0, d_resp0_valid}, 64'd3);
    checkOutput("single_resp1Valid", {62'd0, d_resp1_valid}, 64'd0);
    checkOutput("single_result", {d_resp0_result[1], d_resp0_result[0]}, {32'd12, 32'd12});
    step(1);
    checkOutput("single_resp0Done", {62'd0, d_resp0_valid}, 64'd0);

    // Tie after reset: SUB 10-3 on req0, MUL 6*7 on req1, both held valid.
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    glog0.delete(); glog1.delete(); rlog0.delete(); rlog1.delete();
    applyStimulus(1'b1, 32'd10, 32'd3, 5'd1, 1'b1, 32'd6, 32'd7, 5'd2, 1'b1, 1'b1);
    step(12);
    applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);
    checkOutput("tie_rrGrantCount", glog0.size(), 64'd4);
    checkOutput("tie_fpGrantCount", glog1.size(), 64'd4);
    if (glog0.size() == 4 && glog1.size() == 4) begin
      checkOutput("tie_rrGrants", {60'd0, glog0[0], glog0[1], glog0[2], glog0[3]}, 64'b0101);
      checkOutput("tie_fpGrants", {60'd0, glog1[0], glog1[1], glog1[2], glog1[3]}, 64'b0000);
    end
    checkOutput("tie_rrResultCount", rlog0.size(), 64'd4);
    checkOutput("tie_fpResultCount", rlog1.size(), 64'd4);
    if (rlog0.size() == 4 && rlog1.size() == 4) begin
      checkOutput("tie_rrResults", {rlog0[0], rlog0[1]}, {32'd7, 32'd42});
      checkOutput("tie_fpResults", {rlog1[0], rlog1[3]}, {32'd7, 32'd7});
    end
    step(2);

    // Backpressure on requester 1 with XOR, requester 0 waiting meanwhile.
    applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 32'hFFFF0000, 32'h0F0F0F0F, 5'd3, 1'b1, 1'b0);
    step(1);
    applyStimulus(1'b1, 32'd1, 32'd1, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
    #1;
    checkOutput("bp_req0ReadyExec", {62'd0, d_req0_ready}, 64'd0);
    step(1);
    for (int k = 0; k < 10; k++) begin
      checkOutput("bp_resp1Valid", {62'd0, d_resp1_valid}, 64'd3);
      checkOutput("bp_resp1Result", {d_resp1_result[1], d_resp1_result[0]}, {32'hF0F00F0F, 32'hF0F00F0F});
      checkOutput("bp_req0Ready", {62'd0, d_req0_ready}, 64'd0);
      step(1);
    end
    applyStimulus(1'b1, 32'd1, 32'd1, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);
    #1;
    checkOutput("bp_req0ReadyAtFire", {62'd0, d_req0_ready}, 64'd0);
    step(1);
    checkOutput("bp_req0ReadyAfter", {62'd0, d_req0_ready}, 64'd3);
    step(1);
    applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);
    step(3);

    // Reset during the execute cycle discards the operation.
    applyStimulus(1'b1, 32'd2, 32'd3, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);
    step(1);
    checkOutput("rst_aluBeforeReset", {d_alu_val1[1], d_alu_val1[0]}, {32'd2, 32'd2});
    applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    checkAllZero("midReset");
    step(1);
    rst = 1'b0;
    step(3);
    applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 32'd100, 32'd23, 5'd0, 1'b1, 1'b1);
    step(1);
    applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);
    step(1);
    checkOutput("rst_nextValid", {62'd0, d_resp1_valid}, 64'd3);
    checkOutput("rst_nextResult", {d_resp1_result[1], d_resp1_result[0]}, {32'd123, 32'd123});
    step(2);

    // ALU gating while idle, then an undefined opcode.
    checkAllZero("idle");
    applyStimulus(1'b1, 32'd3, 32'd4, 5'h1F, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);
    step(1);
    checkOutput("undef_aluop", {54'd0, d_alu_aluop[1], d_alu_aluop[0]}, {54'd0, 5'h1F, 5'h1F});
    applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);
    step(1);
    checkOutput("undef_respValid", {62'd0, d_resp0_valid}, 64'd3);
    checkOutput("undef_result", {d_resp0_result[1], d_resp0_result[0]}, 64'd0);
    step(2);

    // Random traffic, checked cycle by cycle by the compare process.
    repeat (600) begin
      rop = 5'($urandom_range(0, 4));
      if (rop == 5'd4) rop = 5'h1F;
      applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom, rop,
                    $urandom_range(0, 3) != 0, $urandom, $urandom, 5'($urandom_range(0, 3)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      step(1);
    end
    applyStimulus(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);
    step(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two requesters, requester 0 (pipeline execute stage) and requester 1 (debug/maintenance port), using a valid/ready handshake on each side. One operation is in flight at a time. The block latches the operands, drives the ALU for exactly one cycle and registers the result. It then holds the result on the owning requester's response channel until that requester accepts it. It sits between the requesters and the ALU's `val1`/`val2`/`aluop`/`is_alu_op` inputs and its `result` output.

## Interface
- `FIXED_PRIO`, default 0: 0 = round-robin between requesters; 1 = requester 0 always wins.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid` / `req1_valid` in 1: requester i presents an operation.
- `req0_ready` / `req1_ready` out 1: operation from requester i accepted this cycle.
- `req0_val1` / `req1_val1` in 32: operand 1.
- `req0_val2` / `req1_val2` in 32: operand 2.
- `req0_aluop` / `req1_aluop` in 5: ALUOP code, passed through unmodified.
- `resp0_valid` / `resp1_valid` out 1: result available for requester i.
- `resp0_ready` / `resp1_ready` in 1: requester i consumes the result.
- `resp0_result` / `resp1_result` out 32: registered ALU result.
- `alu_val1`, `alu_val2` out 32: to ALU `val1`, `val2`.
- `alu_aluop` out 5: to ALU `aluop`.
- `alu_is_alu_op` out 1: to ALU `is_alu_op`.
- `alu_result` in 32: from ALU `result`.

## Operation
- Registers:
  - state ∈ {IDLE, EXEC, RESP}
  - `owner` (1 bit): requester being served
  - `last` (1 bit): last served requester
  - operand registers: val1, val2, aluop
  - result register (32 bits)
- IDLE:
  - Grant selection: if exactly one `reqN_valid` is high, that requester is granted.
  - If both are high, the granted requester is !`last` when FIXED_PRIO=0, or requester 0 when FIXED_PRIO=1.
  - `reqN_ready` is high only for the granted requester and only in IDLE. It is combinational from `req*_valid`, state and `last`.
  - On handshake: latch that requester's val1/val2/aluop, set `owner`, go to EXEC.
  - If no requester is valid, stay in IDLE.
- EXEC (exactly 1 cycle):
  - Drive `alu_val1`/`alu_val2`/`alu_aluop` from the operand registers and set `alu_is_alu_op`=1.
  - Capture `alu_result` into the result register at the closing edge.
  - Go to RESP.
- Outside EXEC, `alu_is_alu_op`=0 and `alu_val1`/`alu_val2`/`alu_aluop` are 0, so the ALU outputs 0.
- RESP:
  - `resp[owner]_valid`=1 and `resp[owner]_result` = result register. The other response valid is 0.
  - When `resp[owner]_ready`=1: set `last`=`owner` and go to IDLE.
  - While waiting, the result holds stable and no request is accepted. Both `req*_ready` are 0 in EXEC and RESP.
- `respN_result` shows the result register whenever `respN_valid`=1 and is 0 otherwise.
- Width rules:
  - No arithmetic in this block; 32-bit values pass through bit-exact.
  - aluop codes with no defined operation are forwarded unchanged; the ALU returns 0 for them.
- Requester dropping valid:
  - A requester that drops valid before its handshake loses nothing.
  - Valid is not required to stay high; no request is queued internally.
- Reset (asynchronous, any state):
  - state=IDLE, `last`=1 (so requester 0 wins the first tie), `owner`=0.
  - Operand and result registers are 0.
  - Any in-flight operation is discarded with no response.

## Timing
- Reset values: all `req*_ready`, `resp*_valid`, `resp*_result`, `alu_*` outputs are 0.
- Accept at edge k → EXEC during cycle k..k+1 → `respN_valid` high in the cycle after edge k+1, i.e. 2 cycles of latency.
- With `resp_ready` held high, the minimum issue interval is 3 cycles per operation.
- The response handshake and a new request acceptance never occur in the same cycle. Acceptance resumes in the IDLE cycle after the response is consumed.
- Round-robin fairness: with both requesters continuously valid, grants alternate 0,1,0,1,…

## Test plan
- Single op: requester 0, ADD, val1=5, val2=7, `resp0_ready`=1 → `req0_ready` pulses 1 cycle; `resp0_valid` for 1 cycle 2 cycles later with `resp0_result`=12; `resp1_valid` stays 0.
- Tie after reset (FIXED_PRIO=0): both valid, req0 SUB 10-3, req1 MUL 6*7 → req0 is served first (result 7), then req1 (result 42). A second tie immediately afterwards grants requester 0 first again, since `last`=1.
- Fixed priority (FIXED_PRIO=1): both continuously valid with ADD 1+1 → requester 0 is granted every time and `req1_ready` never asserts.
- Backpressure: requester 1 XOR 0xFFFF0000 ^ 0x0F0F0F0F with `resp1_ready`=0 for 10 cycles → `resp1_result`=0xF0F00F0F stays stable; `req0_ready` stays 0 while `req0_valid`=1; requester 0 is accepted in the cycle after `resp1_ready` goes 1.
- Reset mid-op: assert `rst` during EXEC → all outputs 0 immediately; after release there is no response for the dropped op and the next request completes normally.
- ALU gating: while idle with no requests, `alu_is_alu_op`=0 and all `alu_*` outputs are 0. An undefined aluop 5'h1F with operands 3 and 4 → response result 0.
